// File: rtl/dpram_fifo_pkg.sv
// Shared types and defaults for the dual-port-RAM FIFO controller.
// Pointer type carries one extra wrap bit above the RAM address.
package dpram_fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

  typedef logic [ADDR_W_DEF:0]   ptr_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit FIFO pointer: increments on inc, async active-low reset.
// Rolls over naturally; the MSB toggles once per lap of the RAM.
module fifo_ptr
  import dpram_fifo_pkg::*;
#(
  parameter int W = ADDR_W_DEF + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a 16x8 dual-port RAM (port 0 write, port 1 read).
// Optional registered almost flags: define DPRAM_FIFO_ALMOST_FLAGS_EN.
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              ram_wr_en,
  output logic              ram_port_en_0,
  output logic [ADDR_W-1:0] ram_addr_0,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_port_en_1,
  output logic [ADDR_W-1:0] ram_addr_1,
  input  logic [DATA_W-1:0] ram_data_out_1,
  output logic [ADDR_W:0]   count,
`ifdef DPRAM_FIFO_ALMOST_FLAGS_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  output logic              full,
  output logic              empty,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW-1:0] count_w;
  logic          full_w;
  logic          empty_w;
  logic          push;
  logic          pop;

  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  fifo_ptr #(.W(PW)) u_wptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (push),
    .ptr  (wptr)
  );

  fifo_ptr #(.W(PW)) u_rptr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pop),
    .ptr  (rptr)
  );

  assign empty_w = (wptr == rptr);
  assign full_w  = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0])
                && (wptr[ADDR_W] != rptr[ADDR_W]);
  assign count_w = wptr - rptr;

  // Handshakes are gated by rst_n so nothing fires while reset is held.
  assign s_ready = rst_n & ~full_w;
  assign m_valid = rst_n & ~empty_w;
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  assign ram_wr_en     = push;
  assign ram_port_en_0 = push;
  assign ram_addr_0    = wptr[ADDR_W-1:0];
  assign ram_data_in   = s_data;
  assign ram_port_en_1 = m_valid;
  assign ram_addr_1    = rptr[ADDR_W-1:0];
  assign m_data        = ram_data_out_1;

  always_comb begin
    ovf_d = ovf_q | (s_valid & full_w);
    unf_d = unf_q | (m_ready & empty_w);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign count   = count_w;
  assign full    = full_w;
  assign empty   = empty_w;
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;

`ifdef DPRAM_FIFO_ALMOST_FLAGS_EN
  localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

  logic [PW-1:0] count_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;

  // Flags come from next-state occupancy so they line up with count.
  always_comb begin
    count_d = count_w
            + {{ADDR_W{1'b0}}, push}
            - {{ADDR_W{1'b0}}, pop};
    af_d    = (count_d >= AF_L);
    ae_d    = (count_d <= AE_L);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= af_d;
      ae_q <= ae_d;
    end
  end

  assign almost_full  = af_q;
  assign almost_empty = ae_q;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural 16x8 RAM.
// Table vectors plus directed fill/drain/stream/error/reset sequences.
module tb_dpram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       ram_wr_en;
  logic       ram_port_en_0;
  logic [3:0] ram_addr_0;
  logic [7:0] ram_data_in;
  logic       ram_port_en_1;
  logic [3:0] ram_addr_1;
  logic [7:0] ram_data_out_1;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       ovf_err;
  logic       unf_err;
`ifdef DPRAM_FIFO_ALMOST_FLAGS_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  int checks = 0;
  int errs   = 0;

  logic [7:0] mem [16];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_wr_en && ram_port_en_0) mem[ram_addr_0] <= ram_data_in;

  assign ram_data_out_1 = ram_port_en_1 ? mem[ram_addr_1] : 8'h00;

  dpram_fifo_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .ram_wr_en     (ram_wr_en),
    .ram_port_en_0 (ram_port_en_0),
    .ram_addr_0    (ram_addr_0),
    .ram_data_in   (ram_data_in),
    .ram_port_en_1 (ram_port_en_1),
    .ram_addr_1    (ram_addr_1),
    .ram_data_out_1(ram_data_out_1),
    .count         (count),
`ifdef DPRAM_FIFO_ALMOST_FLAGS_EN
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
`endif
    .full          (full),
    .empty         (empty),
    .ovf_err       (ovf_err),
    .unf_err       (unf_err)
  );

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       sr;
    logic       mv;
    logic       chkd;
    logic [7:0] md;
    logic       we;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    s_valid = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vt[0] = '{1'b1, 8'hAA, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    vt[1] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b0};
    vt[2] = '{1'b1, 8'hBB, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1};
    vt[3] = '{1'b1, 8'hCC, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hBB, 1'b1};
    vt[4] = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hBB, 1'b0};
    vt[5] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hCC, 1'b0};
    vt[6] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    // reset state, held low
    #1 rst_n = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_wr_en", ram_wr_en, 0);
    chk("rst_pen1", ram_port_en_1, 0);
    chk("rst_ovf", ovf_err, 0);
    chk("rst_unf", unf_err, 0);
`ifdef DPRAM_FIFO_ALMOST_FLAGS_EN
    chk("rst_af", almost_full, 0);
    chk("rst_ae", almost_empty, 1);
`endif
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_s_ready", s_ready, 1);

    // table: first-word latency and push/pop overlap
    for (int i = 0; i < 7; i++) begin
      s_valid = vt[i].sv;
      s_data  = vt[i].sd;
      m_ready = vt[i].mr;
      #1;
      chk($sformatf("v%0d_count", i), count, vt[i].cnt);
      chk($sformatf("v%0d_empty", i), empty, vt[i].emp);
      chk($sformatf("v%0d_full", i), full, vt[i].ful);
      chk($sformatf("v%0d_s_ready", i), s_ready, vt[i].sr);
      chk($sformatf("v%0d_m_valid", i), m_valid, vt[i].mv);
      chk($sformatf("v%0d_wr_en", i), ram_wr_en, vt[i].we);
      if (vt[i].chkd) chk($sformatf("v%0d_m_data", i), m_data, vt[i].md);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b0;

    // fill 16 from reset
    rst_pulse();
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i + 1);
      #1;
      chk($sformatf("fill%0d_count", i), count, i);
      chk($sformatf("fill%0d_addr0", i), ram_addr_0, i);
      chk($sformatf("fill%0d_s_ready", i), s_ready, 1);
`ifdef DPRAM_FIFO_ALMOST_FLAGS_EN
      if (i == 4 || i == 5 || i == 11 || i == 12) begin
        chk($sformatf("fill%0d_af", i), almost_full, (i >= 12) ? 1 : 0);
        chk($sformatf("fill%0d_ae", i), almost_empty, (i <= 4) ? 1 : 0);
      end
`endif
      tick();
      chk($sformatf("ram%0d", i), mem[i], i + 1);
    end
    s_valid = 1'b0;
    #1;
    chk("full_flag", full, 1);
    chk("full_count", count, 16);
    chk("full_s_ready", s_ready, 0);
`ifdef DPRAM_FIFO_ALMOST_FLAGS_EN
    chk("full_af", almost_full, 1);
    chk("full_ae", almost_empty, 0);
`endif

    // overflow attempt
    s_valid = 1'b1;
    s_data  = 8'h55;
    #1;
    chk("ovf_wr_en", ram_wr_en, 0);
    tick();
    chk("ovf_err", ovf_err, 1);
    chk("ovf_count", count, 16);
    chk("ovf_addr0", ram_addr_0, 0);

    // push+pop while full: only the pop happens
    s_data  = 8'hEE;
    m_ready = 1'b1;
    #1;
    chk("fp_s_ready", s_ready, 0);
    chk("fp_wr_en", ram_wr_en, 0);
    chk("fp_m_data", m_data, 8'h01);
    tick();
    chk("fp_count", count, 15);
    s_valid = 1'b0;

    // drain the rest
    for (int i = 1; i < 16; i++) begin
      #1;
      chk($sformatf("drain%0d_m_data", i), m_data, i + 1);
      chk($sformatf("drain%0d_addr1", i), ram_addr_1, i);
      tick();
    end
    m_ready = 1'b0;
    #1;
    chk("drain_empty", empty, 1);
    chk("drain_m_valid", m_valid, 0);
    chk("drain_count", count, 0);

    // underflow attempt
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    chk("unf_err", unf_err, 1);
    chk("unf_count", count, 0);
    chk("unf_addr1", ram_addr_1, 0);
    chk("unf_addr0", ram_addr_0, 0);

    // continuous stream, wraps pointers twice
    rst_pulse();
    s_valid = 1'b1;
    s_data  = 8'h80;
    tick();
    for (int i = 0; i < 40; i++) begin
      s_data  = 8'(8'h81 + i);
      m_ready = 1'b1;
      #1;
      chk($sformatf("st%0d_count", i), count, 1);
      chk($sformatf("st%0d_m_data", i), m_data, 8'h80 + i);
      tick();
    end
    s_valid = 1'b0;
    #1;
    chk("st_last_m_data", m_data, 8'hA8);
    tick();
    m_ready = 1'b0;
    #1;
    chk("st_empty", empty, 1);
    chk("st_addr1", ram_addr_1, 9);
    chk("st_ovf", ovf_err, 0);
    chk("st_unf", unf_err, 0);

    // reset mid-stream at count 7
    rst_pulse();
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h30 + i);
      tick();
    end
    chk("mid_count7", count, 7);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_s_ready", s_ready, 0);
    chk("mid_m_valid", m_valid, 0);
    chk("mid_wr_en", ram_wr_en, 0);
    chk("mid_pen0", ram_port_en_0, 0);
    chk("mid_pen1", ram_port_en_1, 0);
    s_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("mid_rel_empty", empty, 1);
    chk("mid_rel_m_valid", m_valid, 0);
    chk("mid_rel_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
